lsu_ctrl: RTL and testbench

- Load/store control stage directly upstream of DMem.
- Accepts one memory op at a time from execute over a valid/ready handshake and drives DMem's req/addr/write_en/l_unsigned/n_bytes/store_data.
- Splits misaligned accesses into byte accesses, assembles and sign-extends load data, and returns one completion per op to writeback.

---
 rtl/lsu_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store control stage ahead of DMem: one op at a time, byte-splits misaligned accesses.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned ops; otherwise they are rejected via wb_misaligned.
module lsu_ctrl #(
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_write_en,
  input  logic              ex_unsigned,
  input  logic [1:0]        ex_size,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [WORD_W-1:0] ex_store_data,
  input  logic [4:0]        ex_rd,
  output logic              dmem_req,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_write_en,
  output logic              dmem_unsigned,
  output logic [1:0]        dmem_n_bytes,
  output logic [WORD_W-1:0] dmem_store_data,
  input  logic              dmem_addr_err,
  input  logic [WORD_W-1:0] dmem_load_data,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_load,
  output logic [WORD_W-1:0] wb_data,
  output logic              wb_err,
  output logic              wb_misaligned
);

  localparam logic [1:0] LS_SINGLE   = 2'b00;
  localparam logic [1:0] LS_HALFWORD = 2'b01;
  localparam logic [1:0] LS_WORD     = 2'b10;
  localparam logic [1:0] LS_ILLEGAL  = 2'b11;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SplitEn = 1'b1;
`else
  localparam bit SplitEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q;
  logic              op_we_q, op_uns_q, split_q, err_q, mis_q;
  logic [1:0]        op_size_q, cnt_q, last_q;
  logic [ADDR_W-1:0] op_addr_q;
  logic [WORD_W-1:0] op_data_q, asm_q;
  logic [4:0]        op_rd_q;

  logic              ex_mis;
  logic [1:0]        ex_last, cnt_inc;
  logic [WORD_W-1:0] resp_data;

  always_comb begin
    ex_mis  = (ex_size == LS_HALFWORD && ex_addr[0]) ||
              (ex_size == LS_WORD && ex_addr[1:0] != 2'b00);
    ex_last = !ex_mis ? 2'd0 : ((ex_size == LS_WORD) ? 2'd3 : 2'd1);
    cnt_inc = cnt_q + 2'd1;
    // Aligned loads arrive already extended by DMem; split loads are extended here.
    resp_data = asm_q;
    if (split_q) begin
      case (op_size_q)
        LS_SINGLE:   resp_data = op_uns_q ? {24'b0, asm_q[7:0]} : {{24{asm_q[7]}}, asm_q[7:0]};
        LS_HALFWORD: resp_data = op_uns_q ? {16'b0, asm_q[15:0]} : {{16{asm_q[15]}}, asm_q[15:0]};
        default:     resp_data = asm_q;
      endcase
    end
    if (err_q || mis_q || op_we_q) resp_data = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      ex_ready        <= 1'b1;
      op_we_q         <= 1'b0;
      op_uns_q        <= 1'b0;
      split_q         <= 1'b0;
      err_q           <= 1'b0;
      mis_q           <= 1'b0;
      op_size_q       <= '0;
      cnt_q           <= '0;
      last_q          <= '0;
      op_addr_q       <= '0;
      op_data_q       <= '0;
      asm_q           <= '0;
      op_rd_q         <= '0;
      dmem_req        <= 1'b0;
      dmem_addr       <= '0;
      dmem_write_en   <= 1'b0;
      dmem_unsigned   <= 1'b0;
      dmem_n_bytes    <= '0;
      dmem_store_data <= '0;
      wb_valid        <= 1'b0;
      wb_rd           <= '0;
      wb_load         <= 1'b0;
      wb_data         <= '0;
      wb_err          <= 1'b0;
      wb_misaligned   <= 1'b0;
    end else begin
      dmem_req        <= 1'b0;
      dmem_addr       <= '0;
      dmem_write_en   <= 1'b0;
      dmem_unsigned   <= 1'b0;
      dmem_n_bytes    <= '0;
      dmem_store_data <= '0;
      wb_valid        <= 1'b0;
      wb_rd           <= '0;
      wb_load         <= 1'b0;
      wb_data         <= '0;
      wb_err          <= 1'b0;
      wb_misaligned   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (ex_valid && ex_ready) begin
            ex_ready  <= 1'b0;
            op_we_q   <= ex_write_en;
            op_uns_q  <= ex_unsigned;
            op_size_q <= ex_size;
            op_addr_q <= ex_addr;
            op_data_q <= ex_store_data;
            op_rd_q   <= ex_rd;
            split_q   <= ex_mis;
            last_q    <= ex_last;
            cnt_q     <= '0;
            asm_q     <= '0;
            err_q     <= 1'b0;
            mis_q     <= 1'b0;
            if (ex_size == LS_ILLEGAL) begin
              err_q   <= 1'b1;
              state_q <= StResp;
            end else if (ex_mis && !SplitEn) begin
              mis_q   <= 1'b1;
              state_q <= StResp;
            end else begin
              dmem_req        <= 1'b1;
              dmem_addr       <= ex_addr;
              dmem_write_en   <= ex_write_en;
              dmem_unsigned   <= ex_mis | ex_unsigned;
              dmem_n_bytes    <= ex_mis ? LS_SINGLE : ex_size;
              dmem_store_data <= ex_mis ? {24'b0, ex_store_data[7:0]} : ex_store_data;
              state_q         <= StIssue;
            end
          end
        end
        StIssue: state_q <= StWait;
        StWait: begin
          if (!op_we_q) begin
            if (split_q) asm_q[{cnt_q, 3'b000} +: 8] <= dmem_load_data[7:0];
            else         asm_q <= dmem_load_data;
          end
          if (dmem_addr_err) begin
            err_q   <= 1'b1;
            state_q <= StResp;
          end else if (cnt_q == last_q) begin
            state_q <= StResp;
          end else begin
            cnt_q           <= cnt_inc;
            dmem_req        <= 1'b1;
            dmem_addr       <= op_addr_q + ADDR_W'(cnt_inc);
            dmem_write_en   <= op_we_q;
            dmem_unsigned   <= 1'b1;
            dmem_n_bytes    <= LS_SINGLE;
            dmem_store_data <= {24'b0, op_data_q[{cnt_inc, 3'b000} +: 8]};
            state_q         <= StIssue;
          end
        end
        StResp: begin
          wb_valid      <= 1'b1;
          wb_rd         <= op_rd_q;
          wb_load       <= !op_we_q;
          wb_data       <= resp_data;
          wb_err        <= err_q;
          wb_misaligned <= mis_q;
          ex_ready      <= 1'b1;
          state_q       <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed ops, a byte-array DMem model and a scoreboard-driven wb monitor.
module tb_lsu_ctrl;

  localparam logic [31:0] START_ADDR = 32'h0000_1000;
  localparam int          DMEM_SIZE  = 1024;
  localparam logic [1:0]  SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0, ex_write_en = 1'b0, ex_unsigned = 1'b0;
  logic [1:0]  ex_size = 2'b00;
  logic [31:0] ex_addr = '0, ex_store_data = '0;
  logic [4:0]  ex_rd = '0;
  logic        ex_ready;
  logic        dmem_req, dmem_write_en, dmem_unsigned;
  logic [1:0]  dmem_n_bytes;
  logic [31:0] dmem_addr, dmem_store_data;
  logic        dmem_addr_err = 1'b0;
  logic [31:0] dmem_load_data = '0;
  logic        wb_valid, wb_load, wb_err, wb_misaligned;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_write_en(ex_write_en),
    .ex_unsigned(ex_unsigned), .ex_size(ex_size), .ex_addr(ex_addr),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_write_en(dmem_write_en),
    .dmem_unsigned(dmem_unsigned), .dmem_n_bytes(dmem_n_bytes),
    .dmem_store_data(dmem_store_data), .dmem_addr_err(dmem_addr_err),
    .dmem_load_data(dmem_load_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_load(wb_load), .wb_data(wb_data),
    .wb_err(wb_err), .wb_misaligned(wb_misaligned)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // DMem model: little-endian bytes, response valid the cycle after req.
  logic [7:0] mem [DMEM_SIZE];

  function automatic int nbytes(input logic [1:0] n);
    return (n == 2'd0) ? 1 : ((n == 2'd1) ? 2 : 4);
  endfunction

  function automatic logic in_range(input logic [31:0] a, input int nb);
    return (a >= START_ADDR) &&
           (longint'(a) + longint'(nb) <= longint'(START_ADDR) + longint'(DMEM_SIZE));
  endfunction

  function automatic logic [31:0] mem_load(input logic [31:0] a, input logic [1:0] n,
                                           input logic uns);
    int          off = int'(a - START_ADDR);
    logic [31:0] w = '0;
    for (int i = 0; i < nbytes(n); i++) w[8*i +: 8] = mem[off + i];
    if (n == 2'd0)      w = uns ? {24'b0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
    else if (n == 2'd1) w = uns ? {16'b0, w[15:0]} : {{16{w[15]}}, w[15:0]};
    return w;
  endfunction

  always @(posedge clk) begin
    if (dmem_req) begin
      if (!in_range(dmem_addr, nbytes(dmem_n_bytes))) begin
        dmem_addr_err  <= 1'b1;
        dmem_load_data <= '0;
      end else begin
        dmem_addr_err <= 1'b0;
        if (dmem_write_en) begin
          for (int i = 0; i < 4; i++)
            if (i < nbytes(dmem_n_bytes))
              mem[int'(dmem_addr - START_ADDR) + i] <= dmem_store_data[8*i +: 8];
          dmem_load_data <= '0;
        end else begin
          dmem_load_data <= mem_load(dmem_addr, dmem_n_bytes, dmem_unsigned);
        end
      end
    end
  end

  typedef struct {
    logic [4:0]  rd;
    logic        load;
    logic [31:0] data;
    logic        err;
    logic        mis;
    int          reqs;
    int          lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];

  int   req_cnt = 0;
  int   busy_cnt = 0;
  logic idle_bad = 1'b0;

  // Monitor: counts reqs/busy cycles per op and checks every completion against the queue.
  always @(negedge clk) begin
    if (rst) begin
      req_cnt  = 0;
      busy_cnt = 0;
      idle_bad = 1'b0;
    end else begin
      if (dmem_req) req_cnt++;
      else if (dmem_addr != 0 || dmem_write_en || dmem_unsigned || dmem_n_bytes != 0 ||
               dmem_store_data != 0) idle_bad = 1'b1;
      if (!ex_ready) busy_cnt++;
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", {31'b0, wb_valid}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
          chk("wb_load", {31'b0, wb_load}, {31'b0, e.load});
          chk("wb_data", wb_data, e.data);
          chk("wb_err", {31'b0, wb_err}, {31'b0, e.err});
          chk("wb_misaligned", {31'b0, wb_misaligned}, {31'b0, e.mis});
          chk("req_count", req_cnt, e.reqs);
          chk("latency", cyc - e.acc - 1, e.lat);
          chk("ready_low_cycles", busy_cnt, e.lat);
          chk("dmem_idle_zero", {31'b0, idle_bad}, 32'd0);
        end
        req_cnt  = 0;
        busy_cnt = 0;
        idle_bad = 1'b0;
      end
    end
  end

  task automatic offer(input logic we, input logic uns, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                       output logic ok);
    int n = 0;
    @(negedge clk);
    while (!ex_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = ex_ready;
    if (!ok) begin
      chk("ready_timeout", {31'b0, ex_ready}, 32'd1);
      return;
    end
    ex_valid = 1'b1; ex_write_en = we; ex_unsigned = uns; ex_size = size;
    ex_addr = addr; ex_store_data = data; ex_rd = rd;
  endtask

  task automatic after_accept();
    @(posedge clk);
    #1;
    // Junk on the ex_* bus must be ignored while busy.
    ex_valid = 1'b0; ex_write_en = 1'b1; ex_size = SZ_X;
    ex_addr = 32'hFFFF_FFFF; ex_store_data = 32'hA5A5_A5A5; ex_rd = 5'h1F;
  endtask

  task automatic run_op(input logic we, input logic uns, input logic [1:0] size,
                        input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd,
                        input logic [31:0] xd, input logic xerr, input logic xmis,
                        input int xreqs, input int xlat);
    exp_t e;
    logic ok;
    int   n = 0;
    offer(we, uns, size, addr, data, rd, ok);
    if (!ok) return;
    e.rd = rd; e.load = !we; e.data = xd; e.err = xerr; e.mis = xmis;
    e.reqs = xreqs; e.lat = xlat; e.acc = cyc;
    exp_q.push_back(e);
    after_accept();
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("wb_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic ok;
    repeat (3) @(negedge clk);
    chk("reset_ex_ready", {31'b0, ex_ready}, 32'd1);
    chk("reset_ctrl", {22'b0, dmem_req, dmem_write_en, dmem_unsigned, dmem_n_bytes, wb_valid,
                       wb_load, wb_err, wb_misaligned, wb_rd}, 32'd0);
    chk("reset_data", dmem_addr | dmem_store_data | wb_data, 32'd0);
    rst = 1'b0;

    // Aligned word store/load.
    run_op(1, 0, SZ_W, START_ADDR + 28, 32'hDEAD_BEEF, 5'd1, 32'h0, 0, 0, 1, 3);
    run_op(0, 0, SZ_W, START_ADDR + 28, 32'h0, 5'd2, 32'hDEAD_BEEF, 0, 0, 1, 3);
    // Byte and halfword extension.
    run_op(1, 0, SZ_B, START_ADDR + 20, 32'h0000_00EF, 5'd3, 32'h0, 0, 0, 1, 3);
    run_op(0, 0, SZ_B, START_ADDR + 20, 32'h0, 5'd4, 32'hFFFF_FFEF, 0, 0, 1, 3);
    run_op(0, 1, SZ_B, START_ADDR + 20, 32'h0, 5'd5, 32'h0000_00EF, 0, 0, 1, 3);
    run_op(1, 0, SZ_H, START_ADDR + 40, 32'h0000_BEEF, 5'd6, 32'h0, 0, 0, 1, 3);
    run_op(0, 0, SZ_H, START_ADDR + 40, 32'h0, 5'd7, 32'hFFFF_BEEF, 0, 0, 1, 3);
    run_op(0, 1, SZ_H, START_ADDR + 40, 32'h0, 5'd8, 32'h0000_BEEF, 0, 0, 1, 3);
`ifdef LSU_MISALIGN_SPLIT_EN
    run_op(1, 0, SZ_W, START_ADDR + 33, 32'h1122_3344, 5'd9, 32'h0, 0, 0, 4, 9);
    run_op(0, 0, SZ_W, START_ADDR + 33, 32'h0, 5'd10, 32'h1122_3344, 0, 0, 4, 9);
    run_op(1, 0, SZ_B, START_ADDR + 36, 32'h0000_0080, 5'd11, 32'h0, 0, 0, 1, 3);
    run_op(0, 0, SZ_H, START_ADDR + 35, 32'h0, 5'd12, 32'hFFFF_8022, 0, 0, 2, 5);
    run_op(0, 1, SZ_H, START_ADDR + 35, 32'h0, 5'd13, 32'h0000_8022, 0, 0, 2, 5);
    run_op(0, 0, SZ_W, START_ADDR + DMEM_SIZE - 2, 32'h0, 5'd15, 32'h0, 1, 0, 3, 7);
`else
    run_op(1, 0, SZ_W, START_ADDR + 33, 32'h1122_3344, 5'd9, 32'h0, 0, 1, 0, 1);
    run_op(0, 0, SZ_W, START_ADDR + 33, 32'h0, 5'd10, 32'h0, 0, 1, 0, 1);
    run_op(1, 0, SZ_B, START_ADDR + 36, 32'h0000_0080, 5'd11, 32'h0, 0, 0, 1, 3);
    run_op(0, 0, SZ_B, START_ADDR + 36, 32'h0, 5'd12, 32'hFFFF_FF80, 0, 0, 1, 3);
    run_op(0, 1, SZ_H, START_ADDR + 35, 32'h0, 5'd13, 32'h0, 0, 1, 0, 1);
    run_op(0, 0, SZ_W, START_ADDR + DMEM_SIZE - 2, 32'h0, 5'd15, 32'h0, 0, 1, 0, 1);
`endif
    // Error cases: out-of-range aligned word and illegal size.
    run_op(0, 0, SZ_W, START_ADDR + DMEM_SIZE, 32'h0, 5'd14, 32'h0, 1, 0, 1, 3);
    run_op(0, 0, SZ_X, START_ADDR, 32'h0, 5'd16, 32'h0, 1, 0, 0, 1);

    // Reset in the WAIT of an in-flight store: no completion must follow.
`ifdef LSU_MISALIGN_SPLIT_EN
    offer(1, 0, SZ_W, START_ADDR + 45, 32'hCAFE_F00D, 5'd17, ok);
    if (ok) begin
      after_accept();
      repeat (4) @(negedge clk);
`else
    offer(1, 0, SZ_W, START_ADDR + 44, 32'hCAFE_F00D, 5'd17, ok);
    if (ok) begin
      after_accept();
      repeat (2) @(negedge clk);
`endif
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_req", {31'b0, dmem_req}, 32'd0);
      chk("rst_mid_ready", {31'b0, ex_ready}, 32'd1);
      chk("rst_mid_wb", {31'b0, wb_valid}, 32'd0);
      rst = 1'b0;
      repeat (15) @(negedge clk);
    end
    // Fresh op after the abort.
    run_op(0, 0, SZ_W, START_ADDR + 28, 32'h0, 5'd18, 32'hDEAD_BEEF, 0, 0, 1, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
